// File: rtl/load_store_unit.sv
// ============================================================================
//  Module      : load_store_unit
//  Description : Load/store initiator for a byte-addressed data memory, with
//                sign/zero extension and optional misaligned-to-byte splitting.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit #(
    parameter bit SPLIT_MISALIGNED = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_base,
    input  logic [31:0] req_offset,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_fault,
    output logic [2:0]  mem_op,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_in,
    input  logic [31:0] mem_out,
    input  logic        mem_fault
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] ea_q, ea_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  f3_q, f3_d;
    logic        store_q, store_d;
    logic        split_q, split_d;
    logic [1:0]  idx_q, idx_d;
    logic [1:0]  last_q, last_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_in_q, mem_in_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        resp_fault_q, resp_fault_d;

    logic [31:0] w_ea;
    logic        w_invalid;
    logic        w_misal;
    logic [1:0]  w_idx_nx;
    logic [31:0] w_loaded;
    logic [31:0] w_raw;

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
        case (i)
            2'd0:    byte_sel = w[7:0];
            2'd1:    byte_sel = w[15:8];
            2'd2:    byte_sel = w[23:16];
            default: byte_sel = w[31:24];
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] raw);
        case (f3)
            3'b000:  extend = {{24{raw[7]}}, raw[7:0]};
            3'b001:  extend = {{16{raw[15]}}, raw[15:0]};
            3'b100:  extend = {24'b0, raw[7:0]};
            3'b101:  extend = {16'b0, raw[15:0]};
            default: extend = raw;
        endcase
    endfunction

    assign w_ea      = req_base + req_offset;
    assign w_invalid = req_store ? (req_funct3[2] | (req_funct3[1:0] == 2'b11))
                                 : ((req_funct3 == 3'b011) | (req_funct3[2] & req_funct3[1]));
    assign w_misal   = ((req_funct3[1:0] == 2'b01) & w_ea[0]) |
                       ((req_funct3[1:0] == 2'b10) & (w_ea[1:0] != 2'b00));
    assign w_idx_nx  = idx_q + 2'd1;

    // Merge the byte returned for the current split access into the accumulator
    always_comb begin
        w_loaded = acc_q;
        for (int k = 0; k < 4; k++) begin
            if (idx_q == 2'(k)) begin
                w_loaded[8*k +: 8] = mem_out[7:0];
            end
        end
    end

    assign w_raw = split_q ? w_loaded : mem_out;

    always_comb begin
        state_d      = state_q;
        ea_d         = ea_q;
        wdata_d      = wdata_q;
        f3_d         = f3_q;
        store_d      = store_q;
        split_d      = split_q;
        idx_d        = idx_q;
        last_d       = last_q;
        op_d         = op_q;
        acc_d        = acc_q;
        mem_addr_d   = mem_addr_q;
        mem_in_d     = mem_in_q;
        resp_data_d  = resp_data_q;
        resp_fault_d = resp_fault_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (w_invalid || (w_misal && !SPLIT_MISALIGNED)) begin
                        resp_fault_d = 1'b1;
                        resp_data_d  = 32'h0;
                        state_d      = RESP;
                    end else begin
                        ea_d         = w_ea;
                        wdata_d      = req_wdata;
                        f3_d         = req_funct3;
                        store_d      = req_store;
                        split_d      = w_misal;
                        idx_d        = 2'd0;
                        last_d       = w_misal ? ((req_funct3[1:0] == 2'b01) ? 2'd1 : 2'd3) : 2'd0;
                        op_d         = {req_store, w_misal ? 2'b00 : req_funct3[1:0]};
                        acc_d        = 32'h0;
                        mem_addr_d   = w_ea;
                        resp_fault_d = 1'b0;
                        if (req_store) begin
                            if (w_misal || req_funct3[1:0] == 2'b00) begin
                                mem_in_d = {24'b0, req_wdata[7:0]};
                            end else if (req_funct3[1:0] == 2'b01) begin
                                mem_in_d = {16'b0, req_wdata[15:0]};
                            end else begin
                                mem_in_d = req_wdata;
                            end
                        end
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                if (mem_fault) begin
                    resp_fault_d = 1'b1;
                    resp_data_d  = 32'h0;
                    state_d      = RESP;
                end else if (idx_q != last_q) begin
                    acc_d      = w_loaded;
                    idx_d      = w_idx_nx;
                    mem_addr_d = ea_q + {30'b0, w_idx_nx};
                    if (store_q) begin
                        mem_in_d = {24'b0, byte_sel(wdata_q, w_idx_nx)};
                    end
                    state_d = ISSUE;
                end else begin
                    resp_data_d = store_q ? 32'h0 : extend(f3_q, w_raw);
                    state_d     = RESP;
                end
            end
            default: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            ea_q         <= 32'h0;
            wdata_q      <= 32'h0;
            f3_q         <= 3'b000;
            store_q      <= 1'b0;
            split_q      <= 1'b0;
            idx_q        <= 2'd0;
            last_q       <= 2'd0;
            op_q         <= 3'b000;
            acc_q        <= 32'h0;
            mem_addr_q   <= 32'h0;
            mem_in_q     <= 32'h0;
            resp_data_q  <= 32'h0;
            resp_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ea_q         <= ea_d;
            wdata_q      <= wdata_d;
            f3_q         <= f3_d;
            store_q      <= store_d;
            split_q      <= split_d;
            idx_q        <= idx_d;
            last_q       <= last_d;
            op_q         <= op_d;
            acc_q        <= acc_d;
            mem_addr_q   <= mem_addr_d;
            mem_in_q     <= mem_in_d;
            resp_data_q  <= resp_data_d;
            resp_fault_q <= resp_fault_d;
        end
    end

    // Opcode is gated by state so an async reset drops it to a byte read at once
    assign mem_op     = (state_q == ISSUE) ? op_q : 3'b000;
    assign mem_addr   = mem_addr_q;
    assign mem_in     = mem_in_q;
    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_data  = resp_data_q;
    assign resp_fault = resp_fault_q;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Directed bench for load_store_unit with both split settings
//                and a byte-array memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_base, req_offset, req_wdata;
    logic        resp_valid [2];
    logic        resp_ready;
    logic [31:0] resp_data  [2];
    logic        resp_fault [2];
    logic [2:0]  mem_op     [2];
    logic [31:0] mem_addr   [2];
    logic [31:0] mem_in     [2];
    logic [31:0] mem_out    [2];
    logic        mem_fault  [2];

    logic [7:0]  mem [2][256];
    int          ops_cnt [2];
    int          misal_cnt;
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    logic [2:0]  log_op[$];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    load_store_unit #(.SPLIT_MISALIGNED(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_store(req_store), .req_funct3(req_funct3),
        .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready),
        .resp_data(resp_data[0]), .resp_fault(resp_fault[0]),
        .mem_op(mem_op[0]), .mem_addr(mem_addr[0]), .mem_in(mem_in[0]),
        .mem_out(mem_out[0]), .mem_fault(mem_fault[0])
    );

    load_store_unit #(.SPLIT_MISALIGNED(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_store(req_store), .req_funct3(req_funct3),
        .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready),
        .resp_data(resp_data[1]), .resp_fault(resp_fault[1]),
        .mem_op(mem_op[1]), .mem_addr(mem_addr[1]), .mem_in(mem_in[1]),
        .mem_out(mem_out[1]), .mem_fault(mem_fault[1])
    );

    // Memory model: 256 bytes, anything at or above 0x100 faults
    logic [31:0] ma;
    logic        mf;
    logic [31:0] rd;
    logic [7:0]  ix;
    int          nb;
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            ma = mem_addr[u];
            mf = (ma[31:8] != 24'h0);
            nb = (mem_op[u][1:0] == 2'b00) ? 1 : (mem_op[u][1:0] == 2'b01) ? 2 : 4;
            if ((mem_op[u][1:0] == 2'b01 && ma[0]) || (mem_op[u][1:0] == 2'b10 && ma[1:0] != 2'b00) ||
                mem_op[u][1:0] == 2'b11) misal_cnt++;
            if (mem_op[u] != 3'b000) ops_cnt[u]++;
            if (mem_op[u][2]) begin
                if (u == 1) begin
                    log_addr.push_back(ma);
                    log_data.push_back(mem_in[u]);
                    log_op.push_back(mem_op[u]);
                end
                if (!mf) begin
                    for (int k = 0; k < nb; k++) begin
                        ix = ma[7:0] + 8'(k);
                        mem[u][ix] = mem_in[u][8*k +: 8];
                    end
                end
            end
            rd = 32'h0;
            for (int k = 0; k < nb; k++) begin
                ix = ma[7:0] + 8'(k);
                rd[8*k +: 8] = mem[u][ix];
            end
            mem_out[u]   <= mf ? 32'h0 : rd;
            mem_fault[u] <= mf;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        int          u;
        bit          st;
        bit [2:0]    f3;
        bit [31:0]   base;
        bit [31:0]   off;
        bit [31:0]   wd;
        bit [31:0]   exp_d;
        bit          exp_f;
        int          lat;
        int          nnz;
        int          hold;
    } vec_t;

    task automatic do_req(input vec_t v, input int id);
        int lat;
        int ops0;
        ops0       = ops_cnt[v.u];
        req_store  = v.st;
        req_funct3 = v.f3;
        req_base   = v.base;
        req_offset = v.off;
        req_wdata  = v.wd;
        check($sformatf("v%0d req_ready", id), 32'(req_ready[v.u]), 32'h1);
        req_valid[v.u] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[v.u] = 1'b0;
        lat = 1;
        while (!resp_valid[v.u] && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check($sformatf("v%0d latency", id), 32'(lat), 32'(v.lat));
        check($sformatf("v%0d data", id), resp_data[v.u], v.exp_d);
        check($sformatf("v%0d fault", id), 32'(resp_fault[v.u]), 32'(v.exp_f));
        for (int h = 0; h < v.hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("v%0d hold%0d", id, h),
                  {resp_valid[v.u], req_ready[v.u], resp_fault[v.u]}, {v.exp_f ? 3'b101 : 3'b100});
            check($sformatf("v%0d hold%0d data", id, h), resp_data[v.u], v.exp_d);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        check($sformatf("v%0d retire", id), {resp_valid[v.u], req_ready[v.u]}, 2'b01);
        check($sformatf("v%0d mem ops", id), 32'(ops_cnt[v.u] - ops0), 32'(v.nnz));
    endtask

    vec_t tbl[22];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //            u st f3     base       off          wdata        exp_d        f lat nnz hold
        tbl[0]  = '{1, 1, 3'b010, 32'h40,    32'h4,        32'hDEADBEEF, 32'h0,        0, 3, 1, 0};
        tbl[1]  = '{1, 0, 3'b010, 32'h40,    32'h4,        32'h0,        32'hDEADBEEF, 0, 3, 1, 5};
        tbl[2]  = '{1, 0, 3'b000, 32'h10,    32'h0,        32'h0,        32'hFFFFFF80, 0, 3, 0, 0};
        tbl[3]  = '{1, 0, 3'b100, 32'h10,    32'h0,        32'h0,        32'h00000080, 0, 3, 0, 0};
        tbl[4]  = '{1, 0, 3'b001, 32'h10,    32'h2,        32'h0,        32'hFFFF8001, 0, 3, 1, 0};
        tbl[5]  = '{1, 0, 3'b101, 32'h12,    32'h0,        32'h0,        32'h00008001, 0, 3, 1, 0};
        tbl[6]  = '{1, 1, 3'b010, 32'h20,    32'h1,        32'h11223344, 32'h0,        0, 9, 4, 0};
        tbl[7]  = '{1, 0, 3'b010, 32'h21,    32'h0,        32'h0,        32'h11223344, 0, 9, 0, 0};
        tbl[8]  = '{1, 0, 3'b001, 32'h0F,    32'h0,        32'h0,        32'hFFFF8000, 0, 5, 0, 0};
        tbl[9]  = '{1, 0, 3'b010, 32'h50,    32'hFFFFFFF4, 32'h0,        32'hDEADBEEF, 0, 3, 1, 0};
        tbl[10] = '{1, 0, 3'b010, 32'h1000,  32'h0,        32'h0,        32'h0,        1, 3, 1, 0};
        tbl[11] = '{1, 0, 3'b010, 32'hFF,    32'h0,        32'h0,        32'h0,        1, 5, 0, 0};
        tbl[12] = '{1, 1, 3'b100, 32'h40,    32'h0,        32'h1234,     32'h0,        1, 1, 0, 0};
        tbl[13] = '{1, 1, 3'b000, 32'h60,    32'h0,        32'h123456A5, 32'h0,        0, 3, 1, 0};
        tbl[14] = '{1, 0, 3'b000, 32'h60,    32'h0,        32'h0,        32'hFFFFFFA5, 0, 3, 0, 0};
        tbl[15] = '{1, 1, 3'b001, 32'h62,    32'h0,        32'hCAFEBEEF, 32'h0,        0, 3, 1, 0};
        tbl[16] = '{1, 0, 3'b010, 32'h60,    32'h0,        32'h0,        32'hBEEF00A5, 0, 3, 1, 0};
        tbl[17] = '{0, 1, 3'b001, 32'h30,    32'h1,        32'hFFFF,     32'h0,        1, 1, 0, 0};
        tbl[18] = '{0, 0, 3'b011, 32'h40,    32'h0,        32'h0,        32'h0,        1, 1, 0, 0};
        tbl[19] = '{0, 0, 3'b010, 32'h42,    32'h0,        32'h0,        32'h0,        1, 1, 0, 0};
        tbl[20] = '{0, 0, 3'b101, 32'h10,    32'h0,        32'h0,        32'h00000080, 0, 3, 1, 0};
        tbl[21] = '{1, 0, 3'b110, 32'h10,    32'h0,        32'h0,        32'h0,        1, 1, 0, 0};

        for (int u = 0; u < 2; u++) begin
            for (int a = 0; a < 256; a++) mem[u][a] = 8'h00;
            mem[u][8'h10] = 8'h80;
            mem[u][8'h12] = 8'h01;
            mem[u][8'h13] = 8'h80;
            ops_cnt[u]    = 0;
        end
        mem[0][8'h30] = 8'hAA;
        mem[0][8'h31] = 8'hBB;
        mem[0][8'h32] = 8'hCC;
        mem[0][8'h33] = 8'hDD;
        misal_cnt = 0;

        reset_n      = 1'b0;
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        resp_ready   = 1'b0;
        req_store    = 1'b0;
        req_funct3   = 3'b000;
        req_base     = 32'h0;
        req_offset   = 32'h0;
        req_wdata    = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst mem_op", 32'(mem_op[1]), 32'h0);
        check("rst mem_addr", mem_addr[1], 32'h0);
        check("rst mem_in", mem_in[1], 32'h0);
        check("rst resp", {resp_valid[1], resp_fault[1], resp_valid[0]}, 3'b000);
        check("rst resp_data", resp_data[1], 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst req_ready", {req_ready[1], req_ready[0]}, 2'b11);
        // Start from a clean op count so idle cycles are not counted
        ops_cnt[0] = 0;
        ops_cnt[1] = 0;

        for (int i = 0; i < 22; i++) do_req(tbl[i], i);

        check("reject keeps mem", {mem[0][8'h33], mem[0][8'h32], mem[0][8'h31], mem[0][8'h30]}, 32'hDDCCBBAA);
        check("store log size", 32'(log_addr.size()), 32'd7);
        if (log_addr.size() >= 7) begin
            check("SW op", {log_op[0], log_addr[0]}, {3'b110, 32'h44});
            check("SW data", log_data[0], 32'hDEADBEEF);
            for (int k = 0; k < 4; k++) begin
                check($sformatf("split SW op%0d", k), {log_op[1+k], log_addr[1+k]}, {3'b100, 32'h21 + 32'(k)});
            end
            check("split SW b0", log_data[1], 32'h44);
            check("split SW b1", log_data[2], 32'h33);
            check("split SW b2", log_data[3], 32'h22);
            check("split SW b3", log_data[4], 32'h11);
            check("SB mem_in", {log_op[5], log_data[5]}, {3'b100, 32'h000000A5});
            check("SH mem_in", {log_op[6], log_data[6]}, {3'b101, 32'h0000BEEF});
        end

        // Reset during the third byte of a split word store at 0x81
        req_store      = 1'b1;
        req_funct3     = 3'b010;
        req_base       = 32'h80;
        req_offset     = 32'h1;
        req_wdata      = 32'h11223344;
        req_valid[1]   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("mid-split op", {mem_op[1], mem_addr[1]}, {3'b100, 32'h83});
        reset_n = 1'b0;
        #1;
        check("abort mem_op", 32'(mem_op[1]), 32'h0);
        check("abort resp_valid", 32'(resp_valid[1]), 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("abort req_ready", 32'(req_ready[1]), 32'h1);
        check("abort bytes", {mem[1][8'h84], mem[1][8'h83], mem[1][8'h82], mem[1][8'h81]}, 32'h00003344);
        check("no misaligned op", 32'(misal_cnt), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
